multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 34 +++
 rtl/multicycle_ctrl_decoder.sv | 37 +++
 rtl/multicycle_ctrl.sv | 120 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle control unit and its decoder.
package mips_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StTrap   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'b00,
    CauseIllegal = 2'b01,
    CauseTimeout = 2'b10
  } trap_cause_e;

  localparam logic [11:0] ALU_CTRL_INVALID = 12'hFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;

  // Immediate-format ops carry no func field, so the low half of the control word is zero.
  function automatic logic [11:0] imm_ctrl(input logic [5:0] opcode);
    return {opcode, 6'b000000};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction decoder: opcode/func to ALU control word and register write enable.
module multicycle_ctrl_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  output logic [11:0] alu_ctrl_o,
  output logic        write_reg_o
);

  always_comb begin
    alu_ctrl_o  = ALU_CTRL_INVALID;
    write_reg_o = 1'b0;
    case (opcode_i)
      OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: begin
        alu_ctrl_o  = imm_ctrl(opcode_i);
        write_reg_o = 1'b1;
      end
      OP_SW: begin
        alu_ctrl_o  = imm_ctrl(opcode_i);
        write_reg_o = 1'b0;
      end
      OP_RTYPE: begin
        // Only non-trapping addu is supported; overflow-trapping add and the rest are illegal.
        if (func_i == FN_ADDU) begin
          alu_ctrl_o  = {OP_RTYPE, func_i};
          write_reg_o = 1'b1;
        end
      end
      default: begin
        alu_ctrl_o  = ALU_CTRL_INVALID;
        write_reg_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB controller with sticky trap on illegal opcode or fetch timeout.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  output logic        pc_en,
  output logic        reg_we,
  output logic [11:0] alu_ctrl,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam logic [7:0] WaitLast = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  trap_cause_e trap_cause_q, trap_cause_d;
  logic [31:0] ir_q, ir_d;
  logic [11:0] alu_ctrl_q, alu_ctrl_d;
  logic        write_reg_q, write_reg_d;
  logic [31:0] retired_q, retired_d;
  logic [7:0]  wait_q, wait_d;

  logic [11:0] dec_alu_ctrl;
  logic        dec_write_reg;

  multicycle_ctrl_decoder u_decoder (
    .opcode_i    (ir_q[31:26]),
    .func_i      (ir_q[5:0]),
    .alu_ctrl_o  (dec_alu_ctrl),
    .write_reg_o (dec_write_reg)
  );

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    ir_d         = ir_q;
    alu_ctrl_d   = alu_ctrl_q;
    write_reg_d  = write_reg_q;
    retired_d    = retired_q;
    wait_d       = wait_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d      = StTrap;
          trap_cause_d = CauseTimeout;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        alu_ctrl_d  = dec_alu_ctrl;
        write_reg_d = dec_write_reg;
        if (dec_alu_ctrl == ALU_CTRL_INVALID) begin
          state_d      = StTrap;
          trap_cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // Count on entry to WB so the new total is visible during WB itself.
        retired_d = retired_q + 32'd1;
        state_d   = StWb;
      end
      StWb: begin
        wait_d  = 8'd0;
        state_d = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StTrap;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      trap_cause_q <= CauseNone;
      ir_q         <= 32'd0;
      alu_ctrl_q   <= ALU_CTRL_INVALID;
      write_reg_q  <= 1'b0;
      retired_q    <= 32'd0;
      wait_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      ir_q         <= ir_d;
      alu_ctrl_q   <= alu_ctrl_d;
      write_reg_q  <= write_reg_d;
      retired_q    <= retired_d;
      wait_q       <= wait_d;
    end
  end

  assign imem_req   = (state_q == StFetch);
  assign pc_en      = (state_q == StWb);
  assign reg_we     = (state_q == StWb) && write_reg_q;
  assign trap       = (state_q == StTrap);
  assign state      = state_q;
  assign trap_cause = trap_cause_q;
  assign ir         = ir_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of single instructions plus timeout/wrap/reset sequences.
module tb_multicycle_ctrl;

  localparam logic [2:0] SFetch  = 3'd0;
  localparam logic [2:0] SDecode = 3'd1;
  localparam logic [2:0] SExec   = 3'd2;
  localparam logic [2:0] SWb     = 3'd3;
  localparam logic [2:0] STrap   = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr;
  logic [31:0] ir;
  logic        pc_en;
  logic        reg_we;
  logic [11:0] alu_ctrl;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  multicycle_ctrl #(.FETCH_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .ir         (ir),
    .pc_en      (pc_en),
    .reg_we     (reg_we),
    .alu_ctrl   (alu_ctrl),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          delay;
    logic        illegal;
    logic [11:0] alu;
    logic        we;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " state"}, 32'(state), 32'(SFetch));
    chk({tag, " imem_req"}, 32'(imem_req), 32'd1);
    chk({tag, " ir"}, ir, 32'd0);
    chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'hFFF);
    chk({tag, " retired"}, retired, 32'd0);
    chk({tag, " trap"}, 32'(trap), 32'd0);
    chk({tag, " cause"}, 32'(trap_cause), 32'd0);
    chk({tag, " pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, " reg_we"}, 32'(reg_we), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    imem_ack = 1'b0;
    tick();
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  // Starts in the first cycle of FETCH; returns in the first cycle of the next FETCH (or in TRAP).
  task automatic run_vec(input vec_t v, input logic [31:0] exp_retired);
    int start;
    start = cyc;
    for (int i = 0; i < v.delay; i++) begin
      imem_ack = 1'b0;
      instr    = 32'h24080005;
      chk({v.name, " req wait"}, 32'(imem_req), 32'd1);
      tick();
    end
    chk({v.name, " fetch state"}, 32'(state), 32'(SFetch));
    imem_ack = 1'b1;
    instr    = v.instr;
    tick();
    imem_ack = 1'b0;
    instr    = 32'hDEADBEEF;
    chk({v.name, " decode state"}, 32'(state), 32'(SDecode));
    chk({v.name, " ir"}, ir, v.instr);
    chk({v.name, " req in decode"}, 32'(imem_req), 32'd0);
    tick();
    if (v.illegal) begin
      chk({v.name, " trap state"}, 32'(state), 32'(STrap));
      chk({v.name, " trap"}, 32'(trap), 32'd1);
      chk({v.name, " cause"}, 32'(trap_cause), 32'd1);
      chk({v.name, " retired"}, retired, exp_retired - 32'd1);
      imem_ack = 1'b1;
      instr    = 32'h24080005;
      repeat (3) tick();
      imem_ack = 1'b0;
      chk({v.name, " trap held"}, 32'(state), 32'(STrap));
      chk({v.name, " trap req"}, 32'(imem_req), 32'd0);
      chk({v.name, " trap pc_en/we"}, {30'd0, pc_en, reg_we}, 32'd0);
      chk({v.name, " cause held"}, 32'(trap_cause), 32'd1);
    end else begin
      chk({v.name, " exec state"}, 32'(state), 32'(SExec));
      chk({v.name, " exec alu"}, 32'(alu_ctrl), 32'(v.alu));
      chk({v.name, " exec pc_en/we"}, {30'd0, pc_en, reg_we}, 32'd0);
      tick();
      chk({v.name, " wb state"}, 32'(state), 32'(SWb));
      chk({v.name, " wb reg_we"}, 32'(reg_we), 32'(v.we));
      chk({v.name, " wb pc_en"}, 32'(pc_en), 32'd1);
      chk({v.name, " wb alu"}, 32'(alu_ctrl), 32'(v.alu));
      chk({v.name, " wb retired"}, retired, exp_retired);
      tick();
      chk({v.name, " next fetch"}, 32'(state), 32'(SFetch));
      chk({v.name, " next req"}, 32'(imem_req), 32'd1);
      chk({v.name, " next pc_en"}, 32'(pc_en), 32'd0);
      chk({v.name, " cycles"}, 32'(cyc - start), 32'(v.delay + 4));
    end
  endtask

  initial begin
    rst      = 1'b1;
    imem_ack = 1'b0;
    instr    = 32'd0;

    vecs[0] = '{"addiu",   32'h24080005, 0,  1'b0, 12'b001001000000, 1'b1};
    vecs[1] = '{"addiu_d5", 32'h24080005, 5, 1'b0, 12'h240, 1'b1};
    vecs[2] = '{"ori",     32'h34210001, 0,  1'b0, 12'h340, 1'b1};
    vecs[3] = '{"sw",      32'hAC010000, 1,  1'b0, 12'hAC0, 1'b0};
    vecs[4] = '{"addu",    32'h00221821, 0,  1'b0, 12'h021, 1'b1};
    vecs[5] = '{"lui_d15", 32'h3C011234, 15, 1'b0, 12'h3C0, 1'b1};
    vecs[6] = '{"andi",    32'h30420000, 2,  1'b0, 12'h300, 1'b1};
    vecs[7] = '{"add_rtype", 32'h00000020, 0, 1'b1, 12'hFFF, 1'b0};
    vecs[8] = '{"op3f",    32'hFC000000, 3,  1'b1, 12'hFFF, 1'b0};

    repeat (2) @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      do_reset();
      run_vec(vecs[k], 32'd1);
    end

    // Back-to-back retirement without reset.
    do_reset();
    run_vec(vecs[0], 32'd1);
    run_vec(vecs[2], 32'd2);

    // Fetch timeout: 16 ack-less FETCH cycles, TRAP on cycle 17, later ack ignored.
    do_reset();
    repeat (15) tick();
    chk("timeout cycle16 state", 32'(state), 32'(SFetch));
    tick();
    chk("timeout trap state", 32'(state), 32'(STrap));
    chk("timeout cause", 32'(trap_cause), 32'd2);
    chk("timeout trap flag", 32'(trap), 32'd1);
    imem_ack = 1'b1;
    instr    = 32'h24080005;
    repeat (4) tick();
    chk("timeout late ack state", 32'(state), 32'(STrap));
    chk("timeout late ack ir", ir, 32'd0);
    chk("timeout late ack req", 32'(imem_req), 32'd0);
    // Reset while in TRAP with ack high.
    rst = 1'b1;
    tick();
    check_reset_values("rst in trap");
    rst      = 1'b0;
    imem_ack = 1'b0;

    // Retired wraps from all-ones to zero.
    do_reset();
    force dut.retired_q = 32'hFFFFFFFF;
    tick();
    release dut.retired_q;
    #1;
    chk("wrap preload", retired, 32'hFFFFFFFF);
    run_vec(vecs[0], 32'd0);
    chk("wrap trap flag", 32'(trap), 32'd0);

    // Reset during EXEC.
    do_reset();
    imem_ack = 1'b1;
    instr    = 32'h24080005;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("pre-rst exec state", 32'(state), 32'(SExec));
    rst = 1'b1;
    tick();
    check_reset_values("rst in exec");

    // Reset mid-FETCH with ack asserted.
    imem_ack = 1'b1;
    instr    = 32'h34210001;
    tick();
    check_reset_values("rst with ack");
    rst      = 1'b0;
    imem_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
